// File: rtl/alu_result_packer.sv
// alu_result_packer: tags ALU unit results with a header byte, buffers the records in a FIFO
// and streams each record out as bytes (header first, then the result MSB first) over valid/ready.
module alu_result_packer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [2*WIDTH-1:0]     ARITH_OUT,
    input  logic [2*WIDTH-1:0]     LOGIC_OUT,
    input  logic [2*WIDTH-1:0]     CMP_OUT,
    input  logic [2*WIDTH-1:0]     SHIFT_OUT,
    input  logic                   CARRY_OUT,
    input  logic                   ARITH_FLAG_OUT,
    input  logic                   LOGIC_FLAG_OUT,
    input  logic                   CMP_FLAG_OUT,
    input  logic                   SHIFT_FLAG_OUT,
    input  logic                   CLR_OVF,
    output logic [7:0]             OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OVERFLOW,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   BUSY
);
    localparam int NBYTES = 2 * WIDTH / 8;
    localparam int RW = 2 * WIDTH;
    localparam int REC = RW + 8;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           st, nxt;
    logic [REC-1:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic [3:0]       seq;
    logic             ovf;
    logic [7:0]       hdr_r;
    logic [RW-1:0]    dat_r;
    logic [IW-1:0]    idx;
    logic             any, multi, full, empty, wr, pop, hs, last;
    logic [1:0]       unit;
    logic [RW-1:0]    res;
    logic [REC-1:0]   rec_in, head;

    assign any    = ARITH_FLAG_OUT | LOGIC_FLAG_OUT | CMP_FLAG_OUT | SHIFT_FLAG_OUT;
    assign multi  = (ARITH_FLAG_OUT & (LOGIC_FLAG_OUT | CMP_FLAG_OUT | SHIFT_FLAG_OUT)) |
                    (LOGIC_FLAG_OUT & (CMP_FLAG_OUT | SHIFT_FLAG_OUT)) | (CMP_FLAG_OUT & SHIFT_FLAG_OUT);
    assign unit   = ARITH_FLAG_OUT ? 2'd0 : LOGIC_FLAG_OUT ? 2'd1 : CMP_FLAG_OUT ? 2'd2 : 2'd3;
    assign res    = ARITH_FLAG_OUT ? ARITH_OUT : LOGIC_FLAG_OUT ? LOGIC_OUT : CMP_FLAG_OUT ? CMP_OUT : SHIFT_OUT;
    assign rec_in = {unit, ARITH_FLAG_OUT & CARRY_OUT, multi, seq, res};
    assign head   = mem[rd_ptr];
    assign full   = count == LW'(DEPTH);
    assign empty  = count == '0;
    // a full FIFO still accepts when the serializer pops on the same edge
    assign wr     = any & (~full | pop);
    assign hs     = OUT_VALID & OUT_READY;
    assign last   = idx == IW'(NBYTES - 1);

    assign OUT_VALID = st != IDLE;
    assign BUSY      = st != IDLE;
    assign OUT_DATA  = st == HDR ? hdr_r : st == DATA ? dat_r[RW-1 -: 8] : 8'h00;
    assign OVERFLOW  = ovf;
    assign LEVEL     = count;

    always_comb begin
        nxt = st;
        pop = 1'b0;
        case (st)
            IDLE: begin
                pop = ~empty;
                nxt = empty ? IDLE : HDR;
            end
            HDR:  nxt = hs ? DATA : HDR;
            DATA: begin
                pop = hs & last & ~empty;
                nxt = (hs & last) ? (empty ? IDLE : HDR) : DATA;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) st <= IDLE;
        else     st <= nxt;
    end

    always_ff @(posedge CLK) begin
        if (wr) mem[wr_ptr] <= rec_in;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
            ovf    <= 1'b0;
            hdr_r  <= '0;
            dat_r  <= '0;
            idx    <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr & ~pop) count <= count + 1'b1;
            else if (~wr & pop) count <= count - 1'b1;
            if (wr) seq <= seq + 1'b1;
            if (any & ~wr) ovf <= 1'b1;
            else if (CLR_OVF) ovf <= 1'b0;
            if (pop) begin
                hdr_r <= head[REC-1 -: 8];
                dat_r <= head[RW-1:0];
                idx   <= '0;
            end else if (st == DATA && hs) begin
                dat_r <= dat_r << 8;
                idx   <= idx + 1'b1;
            end
        end
    end
endmodule
